// File: rtl/axi4_r_sender_burst.sv
// R-channel sender for the RAB read path: forwards master R beats to the slave port and
// answers every dropped read with a full-length error burst, switching only at burst boundaries.
module axi4_r_sender_burst #(
  parameter int unsigned AXI_DATA_WIDTH  = 32,
  parameter int unsigned AXI_ID_WIDTH    = 4,
  parameter int unsigned AXI_USER_WIDTH  = 4,
  parameter int unsigned DROP_FIFO_DEPTH = 4,
  parameter logic [1:0]  ERR_RESP        = 2'b10,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                      axi4_aclk,
  input  logic                      axi4_arst,

  input  logic [AXI_ID_WIDTH-1:0]   trans_id,
  input  logic [7:0]                trans_len,
  input  logic                      trans_drop,
  output logic                      trans_drop_ready,

  output logic [AXI_ID_WIDTH-1:0]   s_axi4_rid,
  output logic [AXI_DATA_WIDTH-1:0] s_axi4_rdata,
  output logic [1:0]                s_axi4_rresp,
  output logic                      s_axi4_rlast,
  output logic [AXI_USER_WIDTH-1:0] s_axi4_ruser,
  output logic                      s_axi4_rvalid,
  input  logic                      s_axi4_rready,

  input  logic [AXI_ID_WIDTH-1:0]   m_axi4_rid,
  input  logic [AXI_DATA_WIDTH-1:0] m_axi4_rdata,
  input  logic [1:0]                m_axi4_rresp,
  input  logic                      m_axi4_rlast,
  input  logic [AXI_USER_WIDTH-1:0] m_axi4_ruser,
  input  logic                      m_axi4_rvalid,
  output logic                      m_axi4_rready,

  output logic [CNT_WIDTH-1:0]      err_burst_cnt
);

  localparam int unsigned PTR_W   = (DROP_FIFO_DEPTH > 1) ? $clog2(DROP_FIFO_DEPTH) : 1;
  localparam int unsigned ENTRY_W = AXI_ID_WIDTH + 8;

  localparam logic [PTR_W:0]     FIFO_FULL = (PTR_W + 1)'(DROP_FIFO_DEPTH);
  localparam logic [PTR_W:0]     FIFO_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_WIDTH-1:0] ERR_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    DROP
  } state_t;

  state_t state, state_next;

  logic [ENTRY_W-1:0]      fifo_mem [DROP_FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W:0]          fifo_cnt;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;
  logic [AXI_ID_WIDTH-1:0] head_id;
  logic [7:0]              head_len;
  logic [7:0]              beat_cnt;
  logic                    err_last;
  logic                    s_hs;
  logic                    m_hs;

  assign fifo_empty       = (fifo_cnt == '0);
  assign trans_drop_ready = (fifo_cnt != FIFO_FULL);
  assign push             = trans_drop & trans_drop_ready;
  assign head_id          = fifo_mem[rd_ptr][ENTRY_W-1:8];
  assign head_len         = fifo_mem[rd_ptr][7:0];
  assign err_last         = (beat_cnt == head_len);
  assign s_hs             = s_axi4_rvalid & s_axi4_rready;
  assign m_hs             = m_axi4_rvalid & m_axi4_rready;
  assign pop              = (state == DROP) & s_hs & err_last;

  // Drop-request storage carries no reset: entries are only read once the count says they are valid.
  always_ff @(posedge axi4_aclk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {trans_id, trans_len};
    end
  end

  always_ff @(posedge axi4_aclk) begin
    if (axi4_arst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + FIFO_ONE;
        2'b01:   fifo_cnt <= fifo_cnt - FIFO_ONE;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge axi4_aclk) begin
    if (axi4_arst) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      err_burst_cnt <= '0;
    end else begin
      state <= state_next;
      if ((state == DROP) && s_hs) begin
        beat_cnt <= err_last ? 8'd0 : beat_cnt + 8'd1;
      end
      if (pop && (err_burst_cnt != '1)) begin
        err_burst_cnt <= err_burst_cnt + ERR_ONE;
      end
    end
  end

  // Queued drops only win in IDLE, so a master burst already in flight always finishes first.
  always_comb begin
    state_next    = state;
    s_axi4_rid    = m_axi4_rid;
    s_axi4_rdata  = m_axi4_rdata;
    s_axi4_rresp  = m_axi4_rresp;
    s_axi4_rlast  = m_axi4_rlast;
    s_axi4_ruser  = m_axi4_ruser;
    s_axi4_rvalid = m_axi4_rvalid;
    m_axi4_rready = s_axi4_rready;

    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          s_axi4_rvalid = 1'b0;
          m_axi4_rready = 1'b0;
          state_next    = DROP;
        end else if (m_hs && !m_axi4_rlast) begin
          state_next = FWD;
        end
      end
      FWD: begin
        if (m_hs && m_axi4_rlast) begin
          state_next = IDLE;
        end
      end
      DROP: begin
        s_axi4_rvalid = 1'b1;
        s_axi4_rid    = head_id;
        s_axi4_rresp  = ERR_RESP;
        s_axi4_rdata  = '0;
        s_axi4_ruser  = '0;
        s_axi4_rlast  = err_last;
        m_axi4_rready = 1'b0;
        if (s_hs && err_last) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_axi4_r_sender_burst.sv
// Self-checking bench for axi4_r_sender_burst: scoreboard of expected error bursts and master
// beats, checked every cycle, plus a narrow-counter instance to exercise saturation.
module tb_axi4_r_sender_burst;

  localparam int DW    = 32;
  localparam int IW    = 4;
  localparam int UW    = 4;
  localparam int DEPTH = 4;
  localparam logic [1:0] ERR = 2'b10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          arst;
  logic [IW-1:0] trans_id;
  logic [7:0]    trans_len;
  logic          trans_drop, trans_drop_ready;
  logic [IW-1:0] s_rid, m_rid;
  logic [DW-1:0] s_rdata, m_rdata;
  logic [1:0]    s_rresp, m_rresp;
  logic          s_rlast, m_rlast, s_rvalid, m_rvalid, s_rready, m_rready;
  logic [UW-1:0] s_ruser, m_ruser;
  logic [15:0]   err_burst_cnt;

  logic [IW-1:0] sat_rid;
  logic [DW-1:0] sat_rdata;
  logic [1:0]    sat_rresp;
  logic          sat_rlast, sat_rvalid, sat_m_rready, sat_drop_ready;
  logic [UW-1:0] sat_ruser;
  logic [2:0]    sat_err_cnt;

  axi4_r_sender_burst #(
    .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW),
    .DROP_FIFO_DEPTH(DEPTH), .ERR_RESP(ERR), .CNT_WIDTH(16)
  ) dut (
    .axi4_aclk(clk), .axi4_arst(arst),
    .trans_id(trans_id), .trans_len(trans_len), .trans_drop(trans_drop),
    .trans_drop_ready(trans_drop_ready),
    .s_axi4_rid(s_rid), .s_axi4_rdata(s_rdata), .s_axi4_rresp(s_rresp),
    .s_axi4_rlast(s_rlast), .s_axi4_ruser(s_ruser), .s_axi4_rvalid(s_rvalid),
    .s_axi4_rready(s_rready),
    .m_axi4_rid(m_rid), .m_axi4_rdata(m_rdata), .m_axi4_rresp(m_rresp),
    .m_axi4_rlast(m_rlast), .m_axi4_ruser(m_ruser), .m_axi4_rvalid(m_rvalid),
    .m_axi4_rready(m_rready),
    .err_burst_cnt(err_burst_cnt)
  );

  axi4_r_sender_burst #(
    .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW),
    .DROP_FIFO_DEPTH(DEPTH), .ERR_RESP(ERR), .CNT_WIDTH(3)
  ) dut_sat (
    .axi4_aclk(clk), .axi4_arst(arst),
    .trans_id(trans_id), .trans_len(trans_len), .trans_drop(trans_drop),
    .trans_drop_ready(sat_drop_ready),
    .s_axi4_rid(sat_rid), .s_axi4_rdata(sat_rdata), .s_axi4_rresp(sat_rresp),
    .s_axi4_rlast(sat_rlast), .s_axi4_ruser(sat_ruser), .s_axi4_rvalid(sat_rvalid),
    .s_axi4_rready(s_rready),
    .m_axi4_rid(m_rid), .m_axi4_rdata(m_rdata), .m_axi4_rresp(m_rresp),
    .m_axi4_rlast(m_rlast), .m_axi4_ruser(m_ruser), .m_axi4_rvalid(m_rvalid),
    .m_axi4_rready(sat_m_rready),
    .err_burst_cnt(sat_err_cnt)
  );

  typedef struct {logic [IW-1:0] id; logic [DW-1:0] data; logic [UW-1:0] user; logic last;} mbeat_t;
  typedef struct {logic [IW-1:0] id; logic [7:0] len;} drop_t;
  typedef struct {logic [IW-1:0] id; logic last;} ebeat_t;

  mbeat_t mq[$];
  drop_t  dq[$];
  ebeat_t eq[$];

  int errors = 0, checks = 0, cycle = 0;
  int occ = 0, expCnt = 0, expSat = 0;
  int pushCycle = 0, firstErrCycle = -1, lastFwdCycle = -1, errBeatCount = 0;
  bit mMid = 0, eMid = 0, randReady = 0, readyLevel = 1, arstReq = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic addMasterBurst(input logic [IW-1:0] id, input int beats);
    for (int i = 0; i < beats; i++) begin
      mq.push_back('{id: id, data: $urandom() | 32'h1, user: UW'($urandom()), last: (i == beats - 1)});
    end
  endtask

  // One clock cycle: drive at the falling edge, check 1ns later, then book the handshakes.
  task automatic applyStimulus();
    @(negedge clk);
    arst = arstReq;
    m_rresp = 2'b00;
    if (mq.size() > 0) begin
      m_rvalid = 1'b1; m_rid = mq[0].id; m_rdata = mq[0].data;
      m_ruser = mq[0].user; m_rlast = mq[0].last;
    end else begin
      m_rvalid = 1'b0; m_rid = '0; m_rdata = '0; m_ruser = '0; m_rlast = 1'b0;
    end
    if (dq.size() > 0 && occ < DEPTH && !arstReq) begin
      trans_drop = 1'b1; trans_id = dq[0].id; trans_len = dq[0].len;
    end else begin
      trans_drop = 1'b0;
    end
    s_rready = randReady ? 1'($urandom_range(0, 1)) : readyLevel;
    #1;
    checkOutput("drop_ready", trans_drop_ready, 64'(occ < DEPTH));
    checkOutput("err_cnt", err_burst_cnt, 64'(expCnt));
    checkOutput("err_cnt_sat", sat_err_cnt, 64'(expSat));
    if (s_rvalid === 1'b1 && s_rresp === ERR) begin
      checkOutput("err_beat_pending", 64'(eq.size() > 0), 64'(1));
      checkOutput("err_no_interleave", 64'(mMid), 64'(0));
      checkOutput("err_m_rready", m_rready, 64'(0));
      if (eq.size() > 0) begin
        checkOutput("err_rid", s_rid, eq[0].id);
        checkOutput("err_rlast", s_rlast, eq[0].last);
        checkOutput("err_rdata", s_rdata, 64'(0));
        checkOutput("err_ruser", s_ruser, 64'(0));
      end
      if (firstErrCycle < 0) firstErrCycle = cycle;
    end else if (s_rvalid === 1'b1) begin
      checkOutput("fwd_pending", 64'(mq.size() > 0), 64'(1));
      checkOutput("fwd_no_interleave", 64'(eMid), 64'(0));
      checkOutput("fwd_m_rready", m_rready, s_rready);
      if (mq.size() > 0) begin
        checkOutput("fwd_rid", s_rid, mq[0].id);
        checkOutput("fwd_rdata", s_rdata, mq[0].data);
        checkOutput("fwd_rresp", s_rresp, 64'(0));
        checkOutput("fwd_rlast", s_rlast, mq[0].last);
        checkOutput("fwd_ruser", s_ruser, mq[0].user);
      end
    end
    if (m_rvalid && m_rready === 1'b1) begin
      checkOutput("fwd_on_accept", 64'(s_rvalid & s_rready), 64'(1));
    end

    if (arstReq) begin
      eq.delete(); occ = 0; expCnt = 0; expSat = 0; mMid = 0; eMid = 0;
    end else begin
      if (s_rvalid === 1'b1 && s_rready && s_rresp === ERR && eq.size() > 0) begin
        errBeatCount++;
        eMid = !eq[0].last;
        if (eq[0].last) begin
          occ--;
          if (expCnt < 65535) expCnt++;
          if (expSat < 7) expSat++;
        end
        void'(eq.pop_front());
      end
      if (m_rvalid && m_rready === 1'b1 && mq.size() > 0) begin
        mMid = !mq[0].last;
        lastFwdCycle = cycle;
        void'(mq.pop_front());
      end
      if (trans_drop) begin
        for (int i = 0; i <= int'(dq[0].len); i++) begin
          eq.push_back('{id: dq[0].id, last: (i == int'(dq[0].len))});
        end
        occ++;
        pushCycle = cycle;
        void'(dq.pop_front());
      end
    end
    cycle++;
  endtask

  task automatic runUntilIdle(input int limit);
    int n = 0;
    while ((mq.size() + dq.size() + eq.size()) > 0 && n < limit) begin
      applyStimulus();
      n++;
    end
    checkOutput("drained", 64'(mq.size() + dq.size() + eq.size()), 64'(0));
    applyStimulus();
    applyStimulus();
  endtask

  initial begin
    arst = 1'b1; trans_drop = 1'b0; trans_id = '0; trans_len = '0;
    m_rvalid = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_ruser = '0;
    s_rready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    m_rvalid = 1'b1; m_rid = 4'h2; m_rdata = 32'hCAFE0001; m_rlast = 1'b1; s_rready = 1'b0;
    #1;
    checkOutput("rst_drop_ready", trans_drop_ready, 64'(1));
    checkOutput("rst_err_cnt", err_burst_cnt, 64'(0));
    checkOutput("rst_rvalid_pass", s_rvalid, 64'(1));
    checkOutput("rst_rdata_pass", s_rdata, 64'h CAFE0001);
    checkOutput("rst_m_rready_low", m_rready, 64'(0));
    s_rready = 1'b1;
    #1;
    checkOutput("rst_m_rready_high", m_rready, 64'(1));
    m_rvalid = 1'b0;

    // Single drop, full latency from an idle empty queue
    readyLevel = 1; firstErrCycle = -1; errBeatCount = 0;
    dq.push_back('{id: 4'd3, len: 8'd3});
    runUntilIdle(50);
    checkOutput("t1_latency", 64'(firstErrCycle - pushCycle), 64'(2));
    checkOutput("t1_beats", 64'(errBeatCount), 64'(4));
    checkOutput("t1_cnt", err_burst_cnt, 64'(1));

    // Drop arriving mid master burst waits for the master's last beat
    firstErrCycle = -1;
    addMasterBurst(4'd5, 4);
    applyStimulus();
    applyStimulus();
    dq.push_back('{id: 4'd1, len: 8'd0});
    runUntilIdle(50);
    checkOutput("t2_err_after_fwd", 64'(firstErrCycle > lastFwdCycle), 64'(1));

    // Fill the queue while the slave stalls, then drain in order
    readyLevel = 0;
    dq.push_back('{id: 4'd7, len: 8'd0});
    dq.push_back('{id: 4'd8, len: 8'd1});
    dq.push_back('{id: 4'd9, len: 8'd2});
    dq.push_back('{id: 4'd10, len: 8'd1});
    repeat (6) applyStimulus();
    checkOutput("t3_ready_full", trans_drop_ready, 64'(0));
    readyLevel = 1;
    runUntilIdle(100);

    // Random slave stalls across an 8-beat error burst
    randReady = 1; errBeatCount = 0;
    dq.push_back('{id: 4'd6, len: 8'd7});
    runUntilIdle(200);
    checkOutput("t4_beats", 64'(errBeatCount), 64'(8));
    randReady = 0;

    // Reset in the middle of an error burst, then pass-through must resume
    dq.push_back('{id: 4'd12, len: 8'd3});
    for (int n = 0; n < 20 && !(dq.size() == 0 && eq.size() == 2); n++) applyStimulus();
    checkOutput("t5_mid_burst", 64'(eq.size()), 64'(2));
    arstReq = 1;
    applyStimulus();
    arstReq = 0;
    addMasterBurst(4'd9, 2);
    runUntilIdle(50);
    checkOutput("t5_cnt_cleared", err_burst_cnt, 64'(0));

    // Longest burst, then random drops mixed with master traffic
    errBeatCount = 0;
    dq.push_back('{id: 4'd15, len: 8'd255});
    runUntilIdle(400);
    checkOutput("t6_len255_beats", 64'(errBeatCount), 64'(256));
    randReady = 1;
    for (int i = 0; i < 10; i++) begin
      dq.push_back('{id: IW'($urandom()), len: 8'($urandom_range(0, 15))});
      if (i % 3 == 0) addMasterBurst(IW'($urandom()), $urandom_range(1, 4));
    end
    runUntilIdle(3000);
    checkOutput("t6_cnt", err_burst_cnt, 64'(11));
    checkOutput("t6_sat_cnt", sat_err_cnt, 64'(7));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
